// File: rtl/control_fsm_param.sv
// rtl/control_fsm_param.sv - parametrised instruction sequencer (step counter, IR, control decode)
//
// Ports:
//   clock_tb   in   system clock, rising edge
//   resetn_tb  in   asynchronous active-low reset
//   run        in   start request, sampled in T0
//   din        in   instruction word, loaded into ir when ir_en=1
//   g_nz       in   G register non-zero flag (MVNZ condition)
//   ir         out  latched instruction {opcode, rx, ry}
//   step       out  current step, 0=T0 .. 3=T3
//   ir_en      out  IR load strobe
//   rin        out  one-hot register write enable
//   rout       out  register index driven onto the bus
//   rout_en    out  bus source = register
//   din_en     out  bus source = din
//   gout       out  bus source = G
//   dout_en    out  capture bus to output port
//   ain        out  load A
//   gin        out  load G
//   alu_op     out  00 add, 01 sub, 10 and
//   done       out  last step of the instruction
//   illegal    out  undefined opcode or register index out of range
//
// Build option: CU_MVNZ_EN enables opcode 110 as MVNZ; otherwise 110 is illegal.

module control_fsm_param #(
    parameter  int NUM_REGS  = 8,
    parameter  int REG_SEL_W = 3,
    parameter  int OPCODE_W  = 3,
    localparam int IR_W      = OPCODE_W + 2 * REG_SEL_W
) (
    input  logic                 clock_tb,
    input  logic                 resetn_tb,
    input  logic                 run,
    input  logic [IR_W-1:0]      din,
    input  logic                 g_nz,
    output logic [IR_W-1:0]      ir,
    output logic [1:0]           step,
    output logic                 ir_en,
    output logic [NUM_REGS-1:0]  rin,
    output logic [REG_SEL_W-1:0] rout,
    output logic                 rout_en,
    output logic                 din_en,
    output logic                 gout,
    output logic                 dout_en,
    output logic                 ain,
    output logic                 gin,
    output logic [1:0]           alu_op,
    output logic                 done,
    output logic                 illegal
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVO  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    // One extra bit so NUM_REGS == 2**REG_SEL_W is representable.
    localparam logic [REG_SEL_W:0] REG_LIMIT = (REG_SEL_W + 1)'(NUM_REGS);

    logic [2:0]           opcode;
    logic [REG_SEL_W-1:0] rx;
    logic [REG_SEL_W-1:0] ry;
    logic                 rx_bad;
    logic                 ry_bad;
    logic                 is_alu;
    logic                 bad_instr;

    assign opcode = ir[IR_W-1 -: 3];
    assign rx     = ir[2*REG_SEL_W-1 -: REG_SEL_W];
    assign ry     = ir[REG_SEL_W-1:0];
    assign rx_bad = ({1'b0, rx} >= REG_LIMIT);
    assign ry_bad = ({1'b0, ry} >= REG_LIMIT);
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

`ifndef CU_MVNZ_EN
    // g_nz only matters for MVNZ; keep the port but mark it intentionally idle.
    logic g_nz_unused;
    assign g_nz_unused = g_nz;
`endif

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] idx);
        onehot = NUM_REGS'(1) << idx;
    endfunction

    // An instruction is rejected if the opcode is undefined or any register
    // field it actually uses points past the register file.
    always_comb begin
        bad_instr = 1'b0;
        case (opcode)
            OP_MV:            bad_instr = rx_bad | ry_bad;
            OP_MVI, OP_MVO:   bad_instr = rx_bad;
            OP_ADD, OP_SUB,
            OP_AND:           bad_instr = rx_bad | ry_bad;
`ifdef CU_MVNZ_EN
            OP_MVNZ:          bad_instr = rx_bad | ry_bad;
`endif
            default:          bad_instr = 1'b1;
        endcase
    end

    always_ff @(posedge clock_tb or negedge resetn_tb) begin
        if (!resetn_tb) begin
            step <= T0;
            ir   <= '0;
        end else if (step == T0) begin
            if (run) begin
                ir   <= din;
                step <= T1;
            end
        end else if (done) begin
            step <= T0;
        end else begin
            step <= step + 2'd1;
        end
    end

    always_comb begin
        ir_en   = 1'b0;
        rin     = '0;
        rout    = '0;
        rout_en = 1'b0;
        din_en  = 1'b0;
        gout    = 1'b0;
        dout_en = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        alu_op  = 2'b00;
        done    = 1'b0;
        illegal = 1'b0;
        case (step)
            T0: begin
                // step/ir are already cleared during reset; only ir_en follows run directly.
                ir_en = run & resetn_tb;
            end
            T1: begin
                if (bad_instr) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end else begin
                    case (opcode)
                        OP_MV: begin
                            rout    = ry;
                            rout_en = 1'b1;
                            rin     = onehot(rx);
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            din_en = 1'b1;
                            rin    = onehot(rx);
                            done   = 1'b1;
                        end
                        OP_MVO: begin
                            rout    = rx;
                            rout_en = 1'b1;
                            dout_en = 1'b1;
                            done    = 1'b1;
                        end
`ifdef CU_MVNZ_EN
                        OP_MVNZ: begin
                            if (g_nz) begin
                                rout    = ry;
                                rout_en = 1'b1;
                                rin     = onehot(rx);
                            end
                            done = 1'b1;
                        end
`endif
                        default: begin
                            // ALU ops: first operand into A.
                            rout    = rx;
                            rout_en = 1'b1;
                            ain     = 1'b1;
                        end
                    endcase
                end
            end
            T2: begin
                if (is_alu) begin
                    rout    = ry;
                    rout_en = 1'b1;
                    gin     = 1'b1;
                    case (opcode)
                        OP_SUB:  alu_op = 2'b01;
                        OP_AND:  alu_op = 2'b10;
                        default: alu_op = 2'b00;
                    endcase
                end else begin
                    // Unreachable for well-formed sequencing; retire to T0.
                    done = 1'b1;
                end
            end
            default: begin
                if (is_alu) begin
                    gout = 1'b1;
                    rin  = onehot(rx);
                end
                done = 1'b1;
            end
        endcase
    end

endmodule
